vram_port_arbiter: RTL and testbench
====================================

Name: vram_port_arbiter

Overview:
Shares one synchronous RAM port (1-cycle registered read, write-through) between three requesters: ioctl download writer, video fetch and Z80 CPU. Sits between the core's bus logic and port B of the video/system RAM. Port A stays dedicated elsewhere. Serialises accesses with a 3-state FSM and a req/ack handshake per requester.

Parameters:
ADDR_W, 14, RAM address width
DATA_W, 8, RAM data width

Ports:
clk_i  in  1  system clock; all logic on rising edge
reset_i  in  1  synchronous, active-high reset
dl_req_i  in  1  download write request, level, held until ack
dl_addr_i  in  ADDR_W  download address
dl_data_i  in  DATA_W  download write data
dl_ack_o  out  1  one-cycle pulse: download write done
vid_req_i  in  1  video read request, level
vid_addr_i  in  ADDR_W  video address
vid_ack_o  out  1  one-cycle pulse: vid/cpu rd_data_o valid for video
cpu_req_i  in  1  CPU request, level
cpu_we_i  in  1  1 = write, 0 = read
cpu_addr_i  in  ADDR_W  CPU address
cpu_data_i  in  DATA_W  CPU write data
cpu_ack_o  out  1  one-cycle pulse: CPU access done / data valid
rd_data_o  out  DATA_W  read data, valid only in the cycle a read ack is high
ram_addr_o  out  ADDR_W  to RAM port address
ram_data_o  out  DATA_W  to RAM port write data
ram_we_o  out  1  to RAM port write enable
ram_q_i  in  DATA_W  from RAM port registered read data
busy_o  out  1  high in ISSUE and ACK states
grant_o  out  2  00 none, 01 dl, 10 vid, 11 cpu; current owner

Behaviour:
- Reset: state IDLE; all acks 0, ram_we_o 0, ram_addr_o 0, ram_data_o 0, grant_o 00, busy_o 0, last_rr (video/cpu fairness bit) = 0 (cpu favoured next). rd_data_o = ram_q_i passthrough (unqualified outside ack).
- FSM IDLE -> ISSUE -> ACK -> IDLE.
- IDLE (cycle N): if any req high, pick winner, register ram_addr_o/ram_data_o/ram_we_o and grant_o, go ISSUE. No req: stay, ram_we_o 0.
- Priority: dl strictly highest. Between vid and cpu when both request: grant the one not granted last (last_rr: 0 = vid last, 1 = cpu last); single requester always wins. last_rr updates only on vid/cpu grants.
- ISSUE (N+1): RAM samples address/we; ram_we_o high only for dl or cpu write. Next state ACK; ram_we_o cleared at end of ISSUE.
- ACK (N+2): owner's ack high exactly one cycle; for reads rd_data_o = ram_q_i = mem[addr] (write-through data for writes). grant_o held through ACK, cleared to 00 on return to IDLE.
- Latency: req sampled at N -> ack at N+2; peak throughput one access per 3 cycles.
- Requester rule: after ack, req must be low or carry a new request by N+3; arbiter samples again in IDLE at N+3. Changing addr/data/we while req is high and not yet acked is illegal; arbiter latches them only in IDLE.
- Requests arriving during ISSUE/ACK wait; no request is dropped while held.
- Simultaneous dl+vid+cpu: dl served first, then vid/cpu per last_rr; continuous dl requests may starve others (download only runs with CPU halted).
- Reset mid-operation: FSM to IDLE next edge, no ack issued for the in-flight access. A write whose ram_we_o is already high in the reset cycle still lands in RAM; ram_we_o is 0 from the next cycle.
- Width: addresses/data pass unmodified; no arithmetic.

Test Plan:
- Reset: hold reset_i 2 cycles -> all acks 0, ram_we_o 0, grant_o 00, busy_o 0; after release with no reqs, state stays idle.
- Single CPU write then read: cpu write addr 0x0123 data 0xA5 -> ram_we_o=1 at N+1 only, cpu_ack_o at N+2; read 0x0123 -> cpu_ack_o at N+2 with rd_data_o=0xA5.
- Priority: dl, vid, cpu all assert at cycle N -> dl_ack at N+2, vid_ack at N+5 (last_rr reset favours... cpu if reset value 0 means vid last: cpu_ack at N+5, vid_ack at N+8); check order dl, cpu, vid.
- Round-robin: vid and cpu held continuously for 6 accesses -> acks strictly alternate, no requester acked twice in a row.
- Download stream: dl writes 0x00..0x0F with data = addr xor 0x5A, one per 3 cycles -> 16 acks, readback via cpu matches.
- Reset in ISSUE of CPU write to 0x0200 data 0x3C -> no cpu_ack_o, RAM holds 0x3C at 0x0200, next request served normally from IDLE.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// Three-way arbiter (download, video, CPU) in front of one synchronous RAM port.
// Every access runs IDLE -> ISSUE -> ACK, and the owner gets a one-cycle ack.
module vram_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,

    input  logic              dl_req_i,
    input  logic [ADDR_W-1:0] dl_addr_i,
    input  logic [DATA_W-1:0] dl_data_i,
    output logic              dl_ack_o,

    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic              vid_ack_o,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic              cpu_ack_o,

    output logic [DATA_W-1:0] rd_data_o,

    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_q_i,

    output logic              busy_o,
    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_DL   = 2'b01;
    localparam logic [1:0] GNT_VID  = 2'b10;
    localparam logic [1:0] GNT_CPU  = 2'b11;

    state_t              r_state;
    logic                r_last_rr;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_data;
    logic                r_ram_we;
    logic [1:0]          r_grant;
    logic                r_busy;
    logic                r_dl_ack;
    logic                r_vid_ack;
    logic                r_cpu_ack;

    logic [1:0]          w_gnt;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic                w_we;

    // Winner selection: download first, then video/CPU alternate via r_last_rr
    // (0 = video was served last, so CPU goes next).
    always_comb begin
        w_gnt = GNT_NONE;
        if (dl_req_i) begin
            w_gnt = GNT_DL;
        end else if (vid_req_i && cpu_req_i) begin
            w_gnt = r_last_rr ? GNT_VID : GNT_CPU;
        end else if (vid_req_i) begin
            w_gnt = GNT_VID;
        end else if (cpu_req_i) begin
            w_gnt = GNT_CPU;
        end
    end

    always_comb begin
        w_addr = '0;
        w_data = '0;
        w_we   = 1'b0;
        case (w_gnt)
            GNT_DL: begin
                w_addr = dl_addr_i;
                w_data = dl_data_i;
                w_we   = 1'b1;
            end
            GNT_VID: begin
                w_addr = vid_addr_i;
            end
            GNT_CPU: begin
                w_addr = cpu_addr_i;
                w_data = cpu_data_i;
                w_we   = cpu_we_i;
            end
            default: begin
                w_addr = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_last_rr  <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_ram_we   <= 1'b0;
            r_grant    <= GNT_NONE;
            r_busy     <= 1'b0;
            r_dl_ack   <= 1'b0;
            r_vid_ack  <= 1'b0;
            r_cpu_ack  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dl_ack  <= 1'b0;
                    r_vid_ack <= 1'b0;
                    r_cpu_ack <= 1'b0;
                    if (w_gnt != GNT_NONE) begin
                        r_ram_addr <= w_addr;
                        r_ram_data <= w_data;
                        r_ram_we   <= w_we;
                        r_grant    <= w_gnt;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISSUE;
                        if (w_gnt == GNT_VID) begin
                            r_last_rr <= 1'b0;
                        end else if (w_gnt == GNT_CPU) begin
                            r_last_rr <= 1'b1;
                        end
                    end else begin
                        r_ram_we <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    // RAM captures address/we at the end of this cycle; the ack
                    // lines up with its registered read data in the next one.
                    r_ram_we  <= 1'b0;
                    r_dl_ack  <= (r_grant == GNT_DL);
                    r_vid_ack <= (r_grant == GNT_VID);
                    r_cpu_ack <= (r_grant == GNT_CPU);
                    r_state   <= S_ACK;
                end
                S_ACK: begin
                    r_dl_ack  <= 1'b0;
                    r_vid_ack <= 1'b0;
                    r_cpu_ack <= 1'b0;
                    r_grant   <= GNT_NONE;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_ram_we <= 1'b0;
                    r_grant  <= GNT_NONE;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_addr_o = r_ram_addr;
    assign ram_data_o = r_ram_data;
    assign ram_we_o   = r_ram_we;
    assign grant_o    = r_grant;
    assign busy_o     = r_busy;
    assign dl_ack_o   = r_dl_ack;
    assign vid_ack_o  = r_vid_ack;
    assign cpu_ack_o  = r_cpu_ack;
    assign rd_data_o  = ram_q_i;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: behavioural write-through RAM on the port,
// scoreboard of expected acks in service order, plus directed timing checks.
module tb_vram_port_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              dl_req_i;
    logic [ADDR_W-1:0] dl_addr_i;
    logic [DATA_W-1:0] dl_data_i;
    logic              dl_ack_o;
    logic              vid_req_i;
    logic [ADDR_W-1:0] vid_addr_i;
    logic              vid_ack_o;
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_data_i;
    logic              cpu_ack_o;
    logic [DATA_W-1:0] rd_data_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_data_o;
    logic              ram_we_o;
    logic [DATA_W-1:0] ram_q_i;
    logic              busy_o;
    logic [1:0]        grant_o;

    always #5 clk = ~clk;

    vram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .dl_req_i   (dl_req_i),
        .dl_addr_i  (dl_addr_i),
        .dl_data_i  (dl_data_i),
        .dl_ack_o   (dl_ack_o),
        .vid_req_i  (vid_req_i),
        .vid_addr_i (vid_addr_i),
        .vid_ack_o  (vid_ack_o),
        .cpu_req_i  (cpu_req_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_ack_o  (cpu_ack_o),
        .rd_data_o  (rd_data_o),
        .ram_addr_o (ram_addr_o),
        .ram_data_o (ram_data_o),
        .ram_we_o   (ram_we_o),
        .ram_q_i    (ram_q_i),
        .busy_o     (busy_o),
        .grant_o    (grant_o)
    );

    // Synchronous RAM: registered read, write-through
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] model_mem [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (ram_we_o) begin
            ram[ram_addr_o] <= ram_data_o;
            ram_q_i         <= ram_data_o;
        end else begin
            ram_q_i <= ram[ram_addr_o];
        end
    end

    typedef struct {
        logic [1:0]        who;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;
    int   cd, cc, cv, c, prev, s, nack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic expect_acc(input logic [1:0] who, input logic we,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        if (we) model_mem[a] = d;
        e.who  = who;
        e.data = we ? d : model_mem[a];
        sb.push_back(e);
    endtask

    function automatic logic [2:0] ack_vec(input logic [1:0] who);
        case (who)
            2'b01:   return 3'b100;
            2'b10:   return 3'b010;
            2'b11:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Monitor: every ack must match the head of the scoreboard
    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (dl_ack_o || vid_ack_o || cpu_ack_o) begin
            check("ack_onehot", 32'(int'(dl_ack_o) + int'(vid_ack_o) + int'(cpu_ack_o)), 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_ack", {29'd0, dl_ack_o, vid_ack_o, cpu_ack_o}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_owner", {30'd0, grant_o}, {30'd0, mon_e.who});
                check("ack_line", {29'd0, dl_ack_o, vid_ack_o, cpu_ack_o}, {29'd0, ack_vec(mon_e.who)});
                check("rd_data", {24'd0, rd_data_o}, {24'd0, mon_e.data});
            end
        end
    end

    // One access by one requester; called at a negedge, returns at the negedge of its ack
    task automatic acc(input logic [1:0] who, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit push, output int ack_cyc);
        logic got;
        if (push) expect_acc(who, we, a, d);
        case (who)
            2'b01: begin dl_req_i = 1'b1; dl_addr_i = a; dl_data_i = d; end
            2'b10: begin vid_req_i = 1'b1; vid_addr_i = a; end
            default: begin cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = d; end
        endcase
        ack_cyc = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            got = (who == 2'b01) ? dl_ack_o : (who == 2'b10) ? vid_ack_o : cpu_ack_o;
            if (got) begin
                ack_cyc = ncyc;
                break;
            end
        end
        if (ack_cyc < 0) check("ack_timeout", 32'd0, 32'd1);
        case (who)
            2'b01:   dl_req_i = 1'b0;
            2'b10:   vid_req_i = 1'b0;
            default: cpu_req_i = 1'b0;
        endcase
    endtask

    // CPU access with cycle-exact checks of the port and ack timing
    task automatic cpu_timed(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        expect_acc(2'b11, we, a, d);
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = d;
        @(negedge clk);
        check("issue_we", {31'd0, ram_we_o}, {31'd0, we});
        check("issue_addr", {18'd0, ram_addr_o}, {18'd0, a});
        if (we) check("issue_data", {24'd0, ram_data_o}, {24'd0, d});
        check("issue_busy", {31'd0, busy_o}, 32'd1);
        check("issue_grant", {30'd0, grant_o}, 32'd3);
        check("issue_noack", {31'd0, cpu_ack_o}, 32'd0);
        @(negedge clk);
        check("ack_cpu", {31'd0, cpu_ack_o}, 32'd1);
        check("ack_we_low", {31'd0, ram_we_o}, 32'd0);
        check("ack_busy", {31'd0, busy_o}, 32'd1);
        cpu_req_i = 1'b0;
        @(negedge clk);
        check("post_ack", {31'd0, cpu_ack_o}, 32'd0);
        check("post_grant", {30'd0, grant_o}, 32'd0);
        check("post_busy", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i]       = '0;
            model_mem[i] = '0;
        end
        reset_i = 1'b1;
        dl_req_i = 1'b0; dl_addr_i = '0; dl_data_i = '0;
        vid_req_i = 1'b0; vid_addr_i = '0;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_acks", {29'd0, dl_ack_o, vid_ack_o, cpu_ack_o}, 32'd0);
        check("rst_we", {31'd0, ram_we_o}, 32'd0);
        check("rst_grant", {30'd0, grant_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_addr", {18'd0, ram_addr_o}, 32'd0);
        check("rst_data", {24'd0, ram_data_o}, 32'd0);
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", {31'd0, busy_o}, 32'd0);
        check("idle_grant", {30'd0, grant_o}, 32'd0);

        // Single CPU write then read back
        cpu_timed(1'b1, 14'h0123, 8'hA5);
        cpu_timed(1'b0, 14'h0123, 8'h00);

        // All three at once after reset: dl, then cpu, then vid
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        expect_acc(2'b01, 1'b1, 14'h0300, 8'h77);
        expect_acc(2'b11, 1'b0, 14'h0300, 8'h00);
        expect_acc(2'b10, 1'b0, 14'h0123, 8'h00);
        s = ncyc;
        fork
            acc(2'b01, 1'b1, 14'h0300, 8'h77, 1'b0, cd);
            acc(2'b11, 1'b0, 14'h0300, 8'h00, 1'b0, cc);
            acc(2'b10, 1'b0, 14'h0123, 8'h00, 1'b0, cv);
        join
        check("prio_dl_lat", cd - s, 32'd2);
        check("prio_cpu_lat", cc - s, 32'd5);
        check("prio_vid_lat", cv - s, 32'd8);

        // Video and CPU held together: strict alternation starting with CPU
        for (int i = 0; i < 3; i++) begin
            expect_acc(2'b11, 1'b0, 14'h0300, 8'h00);
            expect_acc(2'b10, 1'b0, 14'h0123, 8'h00);
        end
        vid_req_i = 1'b1; vid_addr_i = 14'h0123;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 14'h0300;
        nack = 0;
        for (int k = 0; k < 60 && nack < 6; k++) begin
            @(negedge clk);
            if (vid_ack_o || cpu_ack_o) nack++;
        end
        vid_req_i = 1'b0;
        cpu_req_i = 1'b0;
        check("rr_count", nack, 32'd6);
        @(negedge clk);

        // Download stream, one write per 3 cycles, then CPU readback
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            acc(2'b01, 1'b1, 14'(i), 8'(i) ^ 8'h5A, 1'b1, c);
            if (i > 0) check("dl_spacing", c - prev, 32'd3);
            prev = c;
        end
        for (int i = 0; i < 16; i++) begin
            acc(2'b11, 1'b0, 14'(i), 8'h00, 1'b1, c);
        end

        // Reset during ISSUE of a CPU write: no ack, but the write lands
        @(negedge clk);
        model_mem[14'h0200] = 8'h3C;
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 14'h0200; cpu_data_i = 8'h3C;
        @(negedge clk);
        check("rst_issue_we", {31'd0, ram_we_o}, 32'd1);
        reset_i = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", {31'd0, cpu_ack_o}, 32'd0);
        check("rst_mid_we", {31'd0, ram_we_o}, 32'd0);
        check("rst_mid_grant", {30'd0, grant_o}, 32'd0);
        check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        reset_i = 1'b0;
        cpu_req_i = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_landed", {24'd0, ram[14'h0200]}, 32'h3C);
        cpu_timed(1'b0, 14'h0200, 8'h00);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
